// File: rtl/delay_sink_fifo_pkg.sv
// Shared types for the delay_sink_fifo receive-end buffer.
// Holds the default sizing, the level/in-flight counter type and the error-cause encoding.
package delay_sink_fifo_pkg;

    localparam int unsigned PKG_DEPTH  = 8;
    localparam int unsigned PKG_CNT_BW = $clog2(PKG_DEPTH + 1);

    typedef logic [PKG_CNT_BW-1:0] cnt_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_ORPHAN,
        ERR_OVF
    } err_cause_e;

endpackage

// File: rtl/delay_sink_mem.sv
// DEPTH x DATA_BW register FIFO with write/read pointers and an occupancy level.
// Head is first-word-fall-through; storage is cleared only by reset, never by a pop.
module delay_sink_mem #(
    parameter int unsigned DATA_BW = 10,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CNT_BW  = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [DATA_BW-1:0] i_wdata,
    output logic [DATA_BW-1:0] o_rdata,
    output logic [CNT_BW-1:0]  o_level,
    output logic               o_full,
    output logic               o_empty
);

    localparam int unsigned         PTR_BW   = $clog2(DEPTH);
    localparam logic [PTR_BW-1:0]   PTR_LAST = PTR_BW'(DEPTH - 1);
    localparam logic [CNT_BW-1:0]   LVL_FULL = CNT_BW'(DEPTH);

    logic [DATA_BW-1:0] mem_q [DEPTH];
    logic [PTR_BW-1:0]  wptr_q, wptr_d;
    logic [PTR_BW-1:0]  rptr_q, rptr_d;
    logic [CNT_BW-1:0]  level_q, level_d;

    always_comb begin
        wptr_d = wptr_q;
        if (i_push) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_BW'(1);
        end
    end

    always_comb begin
        rptr_d = rptr_q;
        if (i_pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_BW'(1);
        end
    end

    // Push and pop together leave the level untouched, including at full.
    always_comb begin
        level_d = level_q;
        unique case ({i_push, i_pop})
            2'b10:   level_d = level_q + CNT_BW'(1);
            2'b01:   level_d = level_q - CNT_BW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            if (i_push) begin
                mem_q[wptr_q] <= i_wdata;
            end
        end
    end

    assign o_rdata = mem_q[rptr_q];
    assign o_level = level_q;
    assign o_full  = (level_q == LVL_FULL);
    assign o_empty = (level_q == '0);

endmodule

// File: rtl/delay_sink_fifo.sv
// Credit-gated receive buffer for a fixed-latency, non-stallable pipeline.
// Define DELAY_SINK_ERR_EN to add the sticky o_err protocol-violation flag.
module delay_sink_fifo
    import delay_sink_fifo_pkg::*;
#(
    parameter int unsigned DATA_BW = 10,
    parameter int unsigned DEPTH   = PKG_DEPTH,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNT_BW  = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_issue,
    output logic               o_issue_ok,
    input  logic               i_valid,
    input  logic [DATA_BW-1:0] i_data,
    output logic               o_valid,
    output logic [DATA_BW-1:0] o_data,
    input  logic               i_ready,
    output logic [CNT_BW-1:0]  o_level
`ifdef DELAY_SINK_ERR_EN
    ,
    output logic               o_err
`endif
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("delay_sink_fifo: DEPTH must be at least 2");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("delay_sink_fifo: LATENCY must be at least 1");
    end

    logic [CNT_BW-1:0] inflight_q, inflight_d;
    logic [CNT_BW-1:0] level;
    logic [CNT_BW:0]   credits_used;
    logic              full, empty;
    logic              issue_fire, push, pop;

    // Credit check uses registered counts only, so a pop frees its credit a cycle later.
    assign credits_used = {1'b0, level} + {1'b0, inflight_q};
    assign o_issue_ok   = (credits_used < (CNT_BW + 1)'(DEPTH));
    assign issue_fire   = i_issue & o_issue_ok;

    assign o_valid = ~empty;
    assign pop     = o_valid & i_ready;
    assign push    = i_valid & (inflight_q != '0) & (~full | pop);

    always_comb begin
        inflight_d = inflight_q;
        unique case ({issue_fire, push})
            2'b10:   inflight_d = inflight_q + CNT_BW'(1);
            2'b01:   inflight_d = inflight_q - CNT_BW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    delay_sink_mem #(
        .DATA_BW (DATA_BW),
        .DEPTH   (DEPTH),
        .CNT_BW  (CNT_BW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_pop   (pop),
        .i_wdata (i_data),
        .o_rdata (o_data),
        .o_level (level),
        .o_full  (full),
        .o_empty (empty)
    );

    assign o_level = level;

`ifdef DELAY_SINK_ERR_EN
    err_cause_e err_cause;
    logic       err_q;

    always_comb begin
        err_cause = ERR_NONE;
        if (i_valid && (inflight_q == '0)) begin
            err_cause = ERR_ORPHAN;
        end else if (i_valid && full && !pop) begin
            err_cause = ERR_OVF;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else if (err_cause != ERR_NONE) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`endif

endmodule

// File: tb/tb_delay_sink_fifo.sv
// Directed bench for delay_sink_fifo with a 2-stage issuer pipeline and an in-order scoreboard.
module tb_delay_sink_fifo;
    import delay_sink_fifo_pkg::*;

    localparam int DATA_BW = 10;
    localparam int DEPTH   = 8;

    logic               i_clk   = 1'b0;
    logic               i_rst   = 1'b1;
    logic               i_issue = 1'b0;
    logic               o_issue_ok;
    logic               i_valid = 1'b0;
    logic [DATA_BW-1:0] i_data  = '0;
    logic               o_valid;
    logic [DATA_BW-1:0] o_data;
    logic               i_ready = 1'b0;
    cnt_t               o_level;
`ifdef DELAY_SINK_ERR_EN
    logic               o_err;
`endif

    delay_sink_fifo #(
        .DATA_BW (DATA_BW),
        .DEPTH   (DEPTH),
        .LATENCY (2)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_issue    (i_issue),
        .o_issue_ok (o_issue_ok),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .i_ready    (i_ready),
        .o_level    (o_level)
`ifdef DELAY_SINK_ERR_EN
        ,
        .o_err      (o_err)
`endif
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    logic               s0_v = 1'b0;
    logic [DATA_BW-1:0] s0_d = '0;
    int                 icnt   = 0;
    int                 mlevel = 0;
    int                 mout   = 0;
    logic [DATA_BW-1:0] expq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score the pop, update the model, then advance the issuer pipeline.
    task automatic tick();
        logic               fire, popf, arr;
        logic [DATA_BW-1:0] fdat;
        fire = !i_rst && i_issue && o_issue_ok;
        popf = !i_rst && o_valid && i_ready;
        arr  = !i_rst && i_valid && (mout != 0) && ((mlevel < DEPTH) || popf);
        fdat = DATA_BW'(icnt);
        if (popf) begin
            if (expq.size() == 0) chk("pop_unexpected", 32'(o_data), 32'hFFFF_FFFF);
            else                  chk("pop_data", 32'(o_data), 32'(expq.pop_front()));
        end
        if (fire) begin
            expq.push_back(fdat);
            icnt++;
        end
        mlevel = mlevel + int'(arr) - int'(popf);
        mout   = mout + int'(fire) - int'(arr);
        if (i_rst) begin
            mlevel = 0;
            mout   = 0;
            expq.delete();
        end
        @(posedge i_clk);
        #1;
        i_valid = s0_v;
        i_data  = s0_d;
        s0_v    = fire;
        s0_d    = fdat;
    endtask

    task automatic check_state();
        chk("level", 32'(o_level), 32'(mlevel));
        chk("issue_ok", 32'(o_issue_ok), 32'((mlevel + mout) < DEPTH));
        chk("credit_bound", 32'((int'(o_level) + mout) <= DEPTH), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held for two cycles
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_issue_ok", 32'(o_issue_ok), 32'd1);
        chk("rst_data", 32'(o_data), 32'd0);
`ifdef DELAY_SINK_ERR_EN
        chk("rst_err", 32'(o_err), 32'd0);
`endif

        // credit exhaustion: exactly 8 issues, blocked after the 8th
        icnt    = 0;
        i_issue = 1'b1;
        i_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("exhaust_ok", 32'(o_issue_ok), 32'(k < 7));
            check_state();
        end
        chk("exhaust_issued", 32'(icnt), 32'd8);
        chk("exhaust_level", 32'(o_level), 32'd8);

        // credit recovery after a single pop
        i_issue = 1'b0;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("recover_ok", 32'(o_issue_ok), 32'd1);
        chk("recover_level", 32'(o_level), 32'd7);
        i_issue = 1'b1;
        tick();
        i_issue = 1'b0;
        chk("reblock_ok", 32'(o_issue_ok), 32'd0);
        for (int k = 0; k < 3; k++) tick();
        chk("recover_refill", 32'(o_level), 32'd8);
        chk("recover_issued", 32'(icnt), 32'd9);

        i_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_state();
        end
        chk("drain_valid", 32'(o_valid), 32'd0);
        chk("drain_left", 32'(expq.size()), 32'd0);

        // streaming: o_valid rises three cycles after the first issue
        i_rst = 1'b1;
        tick();
        i_rst   = 1'b0;
        icnt    = 0;
        i_issue = 1'b1;
        i_ready = 1'b1;
        tick();
        chk("stream_v1", 32'(o_valid), 32'd0);
        tick();
        chk("stream_v2", 32'(o_valid), 32'd0);
        tick();
        chk("stream_v3", 32'(o_valid), 32'd1);
        chk("stream_head", 32'(o_data), 32'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check_state();
            chk("stream_lvl", 32'(o_level <= 1), 32'd1);
        end
        i_issue = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("stream_empty", 32'(o_valid), 32'd0);
        chk("stream_left", 32'(expq.size()), 32'd0);

        // random stress with a stalling consumer
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        icnt  = 0;
        for (int k = 0; k < 300; k++) begin
            i_issue = ($urandom_range(0, 3) != 0);
            i_ready = 1'($urandom_range(0, 1));
            tick();
            check_state();
        end
        i_issue = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        chk("stress_empty", 32'(o_valid), 32'd0);
        chk("stress_left", 32'(expq.size()), 32'd0);

        // orphan result with nothing outstanding
`ifdef DELAY_SINK_ERR_EN
        chk("orphan_err_pre", 32'(o_err), 32'd0);
`endif
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 10'h155;
        tick();
        chk("orphan_level", 32'(o_level), 32'd0);
        chk("orphan_valid", 32'(o_valid), 32'd0);
`ifdef DELAY_SINK_ERR_EN
        chk("orphan_err", 32'(o_err), 32'd1);
        tick();
        chk("orphan_err_sticky", 32'(o_err), 32'd1);
`endif

        // reset with two results still in flight
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
`ifdef DELAY_SINK_ERR_EN
        chk("midrst_err_clr", 32'(o_err), 32'd0);
`endif
        icnt    = 0;
        i_issue = 1'b1;
        tick();
        tick();
        i_issue = 1'b0;
        i_rst   = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_state();
            chk("midrst_valid", 32'(o_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
